// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter in front of a single-port synchronous RAM.
// Each access runs IDLE -> ACCESS -> RESP. Requester B (program loader) wins
// ties by default. Define MEM_ARBITER_ROUND_ROBIN_EN to give ties to the
// requester that was not granted last.
module mem_arbiter #(
  parameter int WIDTH         = 8,
  parameter int ADDRESS_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     a_req,
  input  logic                     a_we,
  input  logic [ADDRESS_WIDTH-1:0] a_addr,
  input  logic [WIDTH-1:0]         a_wdata,
  output logic                     a_ack,
  output logic [WIDTH-1:0]         a_rdata,
  input  logic                     b_req,
  input  logic                     b_we,
  input  logic [ADDRESS_WIDTH-1:0] b_addr,
  input  logic [WIDTH-1:0]         b_wdata,
  output logic                     b_ack,
  output logic [WIDTH-1:0]         b_rdata,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic                     ram_we,
  output logic [WIDTH-1:0]         ram_wdata,
  input  logic [WIDTH-1:0]         ram_rdata,
  output logic                     owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                     state, state_next;
  logic [ADDRESS_WIDTH-1:0]   lat_addr;
  logic [WIDTH-1:0]           lat_wdata;
  logic                       lat_we;
  logic                       lat_b;      // 1 = current transaction belongs to B
  logic                       prio_b;
  logic                       grant_b;
  logic                       any_req;

  // Tie-break selection: B always, or whoever was not granted last.
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  assign prio_b = ~owner;
`else
  assign prio_b = 1'b1;
`endif

  assign any_req = a_req | b_req;
  assign grant_b = b_req & (~a_req | prio_b);

  // Next-state decode and RAM/handshake outputs.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_next = state;
    ram_addr   = '0;
    ram_wdata  = '0;
    ram_we     = 1'b0;
    a_ack      = 1'b0;
    b_ack      = 1'b0;
    unique case (state)
      IDLE: begin
        if (any_req) state_next = ACCESS;
      end
      ACCESS: begin
        ram_addr   = lat_addr;
        ram_wdata  = lat_wdata;
        ram_we     = lat_we;
        state_next = RESP;
      end
      RESP: begin
        ram_addr   = lat_addr;
        ram_wdata  = lat_wdata;
        a_ack      = ~lat_b;
        b_ack      = lat_b;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register, winner latch, owner and registered read data.
  always_ff @(posedge clk) begin
    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    if (rst) begin
      // NOTE: reset is synchronous; only control and data registers exist
      // here, the RAM itself lives outside and is never cleared by reset.
      state     <= IDLE;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_we    <= 1'b0;
      lat_b     <= 1'b0;
      owner     <= 1'b0;
      a_rdata   <= '0;
      b_rdata   <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && any_req) begin
        lat_b     <= grant_b;
        owner     <= grant_b;
        lat_addr  <= grant_b ? b_addr  : a_addr;
        lat_wdata <= grant_b ? b_wdata : a_wdata;
        lat_we    <= grant_b ? b_we    : a_we;
      end
      // RAM read data is valid during RESP; capture it as RESP ends.
      if (state == RESP && !lat_we) begin
        if (lat_b) b_rdata <= ram_rdata;
        else       a_rdata <= ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a synchronous RAM model
// (write on the edge, read data registered one cycle after the address).
module tb_mem_arbiter;

  localparam int W  = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [W-1:0]  a_wdata, b_wdata;
  logic          a_ack, b_ack;
  logic [W-1:0]  a_rdata, b_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [W-1:0]  ram_wdata;
  logic [W-1:0]  ram_rdata;
  logic          owner;

  logic [W-1:0]  mem [0:(1<<AW)-1];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.WIDTH(W), .ADDRESS_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .owner(owner)
  );

  // RAM model: synchronous write, read data valid one cycle after address.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  // One complete transaction from an otherwise idle arbiter.
  task automatic txn(input logic is_b, input logic we, input logic [AW-1:0] addr,
                     input logic [W-1:0] wdata);
    if (is_b) begin b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata; end
    else      begin a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata; end
    cycle();  // ACCESS
    check("txn_access_we",   ram_we,   we);
    check("txn_access_addr", ram_addr, addr);
    check("txn_access_ack",  {a_ack, b_ack}, 2'b00);
    cycle();  // RESP
    check("txn_resp_ack",    {a_ack, b_ack}, is_b ? 2'b01 : 2'b10);
    check("txn_resp_we",     ram_we, 1'b0);
    check("txn_owner",       owner,  is_b);
    a_req = 1'b0;
    b_req = 1'b0;
    cycle();  // IDLE
    check("txn_idle_ack",    {a_ack, b_ack}, 2'b00);
    check("txn_idle_addr",   ram_addr, 0);
  endtask

  initial begin
    int acks;
    int k;
    for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
    mem[3] = 8'h2E;
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
    do_reset();

    // Reset state
    check("rst_acks",    {a_ack, b_ack}, 2'b00);
    check("rst_ram_we",  ram_we, 1'b0);
    check("rst_owner",   owner, 1'b0);
    check("rst_a_rdata", a_rdata, 0);
    check("rst_b_rdata", b_rdata, 0);
    check("rst_addr",    ram_addr, 0);

    // A reads addr 3
    txn(1'b0, 1'b0, 4'h3, 8'h00);
    check("a_read3", a_rdata, 8'h2E);
    check("b_rdata_untouched", b_rdata, 0);

    // B writes 0xA5 to 0xF, A reads it back
    txn(1'b1, 1'b1, 4'hF, 8'hA5);
    check("b_write_no_rdata", b_rdata, 0);
    txn(1'b0, 1'b0, 4'hF, 8'h00);
    check("a_readF", a_rdata, 8'hA5);

    // Simultaneous requests from reset owner 0: B wins first in both modes
    a_req = 1; a_we = 0; a_addr = 4'h3;
    b_req = 1; b_we = 0; b_addr = 4'hF;
    cycle();  // N+1 ACCESS
    check("tie_owner_b", owner, 1'b1);
    check("tie_addr_b",  ram_addr, 4'hF);
    cycle();  // N+2 RESP
    check("tie_b_ack", {a_ack, b_ack}, 2'b01);
    b_req = 0;
    cycle();  // N+3 IDLE
    check("tie_idle", {a_ack, b_ack}, 2'b00);
    check("tie_b_rdata", b_rdata, 8'hA5);
    cycle();  // N+4 ACCESS
    check("tie_addr_a", ram_addr, 4'h3);
    check("tie_owner_a", owner, 1'b0);
    cycle();  // N+5 RESP
    check("tie_a_ack", {a_ack, b_ack}, 2'b10);
    a_req = 0;
    cycle();
    check("tie_a_rdata", a_rdata, 8'h2E);

    // Reset during ACCESS of a B write: no ack, write still commits
    b_req = 1; b_we = 1; b_addr = 4'h5; b_wdata = 8'h77;
    cycle();  // ACCESS
    check("rstacc_we", ram_we, 1'b1);
    check("rstacc_owner", owner, 1'b1);
    rst = 1;
    cycle();
    rst = 0;
    b_req = 0;
    check("rstacc_ack",     {a_ack, b_ack}, 2'b00);
    check("rstacc_we_off",  ram_we, 1'b0);
    check("rstacc_owner0",  owner, 1'b0);
    check("rstacc_a_rdata", a_rdata, 0);
    cycle();
    check("rstacc_idle_ack", {a_ack, b_ack}, 2'b00);
    check("rstacc_idle_addr", ram_addr, 0);
    txn(1'b0, 1'b0, 4'h5, 8'h00);
    check("rstacc_committed", a_rdata, 8'h77);

    // A drops its request during ACCESS: one ack, no second transaction
    a_req = 1; a_we = 0; a_addr = 4'h3;
    acks = 0;
    cycle();  // ACCESS
    a_req = 0;
    for (int i = 0; i < 6; i++) begin
      if (a_ack) acks++;
      check("drop_no_b_ack", b_ack, 1'b0);
      cycle();
    end
    check("drop_ack_count", acks, 1);
    check("drop_idle_addr", ram_addr, 0);
    check("drop_a_rdata", a_rdata, 8'h2E);

    // Both requesting continuously from reset: acks every 3 cycles
    do_reset();
    a_req = 1; a_we = 0; a_addr = 4'h3;
    b_req = 1; b_we = 0; b_addr = 4'hF;
    k = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (i % 3 == 1) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        check("cont_ack", {a_ack, b_ack}, (k % 2 == 0) ? 2'b01 : 2'b10);
`else
        check("cont_ack", {a_ack, b_ack}, 2'b01);
`endif
        k++;
      end else begin
        check("cont_no_ack", {a_ack, b_ack}, 2'b00);
      end
    end
    check("cont_ack_total", k, 4);
    a_req = 0;
    b_req = 0;
    cycle();
    cycle();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WIDTH, default 8: RAM data width.
REQ-002 Parameter ADDRESS_WIDTH, default 4: RAM address width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 a_req  input  1  requester A (CPU) access request.
REQ-006 a_we  input  1  requester A write (1) / read (0).
REQ-007 a_addr  input  ADDRESS_WIDTH  requester A address.
REQ-008 a_wdata  input  WIDTH  requester A write data.
REQ-009 a_ack  output  1  requester A one-cycle completion pulse.
REQ-010 a_rdata  output  WIDTH  requester A read data, registered.
REQ-011 b_req  input  1  requester B (program loader) access request.
REQ-012 b_we  input  1  requester B write/read.
REQ-013 b_addr  input  ADDRESS_WIDTH  requester B address.
REQ-014 b_wdata  input  WIDTH  requester B write data.
REQ-015 b_ack  output  1  requester B one-cycle completion pulse.
REQ-016 b_rdata  output  WIDTH  requester B read data, registered.
REQ-017 ram_addr  output  ADDRESS_WIDTH  shared RAM address.
REQ-018 ram_we  output  1  shared RAM write strobe.
REQ-019 ram_wdata  output  WIDTH  shared RAM write data.
REQ-020 ram_rdata  input  WIDTH  shared RAM read data, valid one cycle after address presented.
REQ-021 owner  output  1  last granted requester: 0 = A, 1 = B.

Function
REQ-022 FSM states IDLE, ACCESS, RESP; IDLE->ACCESS when any req sampled high; ACCESS->RESP unconditionally; RESP->IDLE unconditionally.
REQ-023 On IDLE->ACCESS, winner's addr, we, wdata latched; owner updated to winner.
REQ-024 Default arbitration: fixed priority, B over A when both requests are high in the same cycle.
REQ-025 ACCESS: ram_addr/ram_wdata = latched values; ram_we = latched we; ram_we SHALL be 0 in every other state.
REQ-026 RESP: ram_addr held; winner's ack = 1 for exactly one cycle; on a read, winner's rdata loads ram_rdata at the end of RESP.
REQ-027 Latency: req sampled at edge N -> ack high in cycle N+2; max throughput one access per 3 cycles.
REQ-028 Requester holds req and payload stable until ack; deasserts on the edge where ack is sampled; arbiter therefore sees the next request no earlier than the IDLE following RESP.
REQ-029 Request deasserted during ACCESS/RESP ignored; transaction completes and ack still pulses.
REQ-030 Loser's request stays pending and is served in a later IDLE; no request is dropped.
REQ-031 ram_addr and ram_wdata = 0 in IDLE.
REQ-032 x_rdata holds its value except on that requester's read completion; writes leave it unchanged.
REQ-033 a_ack and b_ack never high in the same cycle.

Reset
REQ-034 rst high at an edge: state IDLE, latches 0, owner 0, a_rdata/b_rdata 0, acks 0, ram_we 0, regardless of current state.
REQ-035 Reset during ACCESS/RESP aborts the transaction without ack; a RAM write already committed at an earlier edge is not undone.

Configuration
REQ-036 Macro MEM_ARBITER_ROUND_ROBIN_EN.
REQ-037 Defined: on simultaneous requests, grant goes to the requester not equal to owner; reset owner 0, so first tie goes to B.
REQ-038 Undefined: fixed priority per REQ-024; owner still reports last grant.

Verification
REQ-039 RAM[3]=0x2E, A read addr 3 at edge N -> a_ack high cycle N+2, a_rdata=0x2E afterwards, b_ack stays 0.
REQ-040 B write addr 0xF data 0xA5, then A read 0xF -> ram_we high exactly one cycle; a_rdata=0xA5.
REQ-041 A and B request same cycle, macro undefined -> b_ack at N+2, a_ack at N+5, owner 1 then 0.
REQ-042 Macro defined, A and B requesting continuously -> ack order B,A,B,A, acks 3 cycles apart.
REQ-043 rst asserted while in ACCESS for a write -> no ack, next cycle IDLE, ram_we 0, owner 0.
REQ-044 a_req dropped during ACCESS -> a_ack still pulses once; no second transaction starts.
